// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the memory port arbiter.
//   arb_state_e : FSM states (IDLE grant, ADDR handshake, DATA response)
//   OWN_*       : owner register codes
//   SZ_*        : access size codes, matching the data_mem_sel encoding
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_req_latch.sv
// arb_req_latch: enable register holding the fields of the granted request.
//   clk, rst   : clock, synchronous active-high reset (clears all fields)
//   en_i       : load the *_i fields this cycle
//   addr_i/o   : request address
//   wr_i/o     : 1 = write
//   size_i/o   : access size code
//   wstrb_i/o  : byte enables
//   wdata_i/o  : write data
module arb_req_latch #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wr_i,
    input  logic [1:0]    size_i,
    input  logic [3:0]    wstrb_i,
    input  logic [DW-1:0] wdata_i,
    output logic [AW-1:0] addr_o,
    output logic          wr_o,
    output logic [1:0]    size_o,
    output logic [3:0]    wstrb_o,
    output logic [DW-1:0] wdata_o
);

    logic [AW+DW+6:0] fields_q;

    always_ff @(posedge clk) begin
        if (rst) fields_q <= '0;
        else if (en_i) fields_q <= {addr_i, wr_i, size_i, wstrb_i, wdata_i};
    end

    assign {addr_o, wr_o, size_o, wstrb_o, wdata_o} = fields_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like port between instruction fetch and data access.
//   clk, rst                    : clock, synchronous active-high reset
//   inst_req/inst_addr          : fetch request; inst_addr_ok / inst_data_ok handshake back
//   data_req/wr/size/wstrb/addr/wdata : data request; data_addr_ok / data_data_ok back
//   rdata                       : read data, valid only with the owner's data_ok
//   m_req/wr/size/wstrb/addr/wdata : downstream request, held through the address phase
//   m_addr_ok, m_data_ok, m_rdata  : downstream handshake and read data
//   busy                        : a transaction is in flight
// Data wins arbitration unless fetch has already been passed over STARVE_MAX times in a row.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [3:0]    data_wstrb,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] rdata,
    output logic          m_req,
    output logic          m_wr,
    output logic [1:0]    m_size,
    output logic [3:0]    m_wstrb,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_addr_ok,
    input  logic          m_data_ok,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] cnt_q, cnt_d;
    logic       idle, grant_data, grant_inst, grant, resp;

    // Every handshake output is gated with ~rst so nothing fires during the reset cycle.
    assign idle       = ~rst & (state_q == ARB_IDLE);
    assign grant_data = idle & data_req & ~(inst_req & (cnt_q == CNT_MAX));
    assign grant_inst = idle & inst_req & ~grant_data;
    assign grant      = grant_data | grant_inst;
    assign resp       = ~rst & (state_q == ARB_DATA) & m_data_ok;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        state_d = (state_q == ARB_IDLE) ? (grant ? ARB_ADDR : ARB_IDLE) :
                  (state_q == ARB_ADDR) ? (m_addr_ok ? ARB_DATA : ARB_ADDR) :
                  (m_data_ok ? ARB_IDLE : ARB_DATA);
        owner_d = grant ? grant_data : owner_q;
        // Counts data grants that made a waiting fetch wait; never passes CNT_MAX.
        cnt_d   = grant_inst ? 4'd0 :
                  grant_data ? (inst_req ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1) : 4'd0) :
                  cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_INST;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Fetches are always word reads; reads never carry byte enables downstream.
    arb_req_latch #(.AW(AW), .DW(DW)) u_req_latch (
        .clk     (clk),
        .rst     (rst),
        .en_i    (grant),
        .addr_i  (grant_data ? data_addr : inst_addr),
        .wr_i    (grant_data & data_wr),
        .size_i  (grant_data ? data_size : SZ_WORD),
        .wstrb_i ((grant_data & data_wr) ? data_wstrb : 4'b0000),
        .wdata_i (grant_data ? data_wdata : '0),
        .addr_o  (m_addr),
        .wr_o    (m_wr),
        .size_o  (m_size),
        .wstrb_o (m_wstrb),
        .wdata_o (m_wdata)
    );

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = resp & (owner_q == OWN_INST);
    assign data_data_ok = resp & (owner_q == OWN_DATA);
    assign rdata        = m_rdata;
    assign m_req        = ~rst & (state_q == ARB_ADDR);
    assign busy         = ~rst & (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.STARVE_MAX(SM), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .rdata(rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: one transaction in flight, either waiting for
    // its address to be taken or waiting for its response.
    bit          t_live, t_sent, t_data;
    logic [31:0] t_addr, t_wdata;
    logic        t_wr;
    logic [1:0]  t_size;
    logic [3:0]  t_wstrb;
    int          passed_over;
    bit          e_gd, e_gi;
    logic [5:0]  e_ctrl;

    task automatic model_clear();
        t_live = 0; t_sent = 0; t_data = 0; passed_over = 0;
        t_addr = '0; t_wdata = '0; t_wr = 0; t_size = '0; t_wstrb = '0;
    endtask

    task automatic model_eval();
        e_gd = !rst && !t_live && data_req && !(inst_req && passed_over >= SM);
        e_gi = !rst && !t_live && inst_req && !e_gd;
        e_ctrl = {e_gi, !rst && t_live && t_sent && !t_data && m_data_ok,
                  e_gd, !rst && t_live && t_sent && t_data && m_data_ok,
                  !rst && t_live && !t_sent, !rst && t_live};
    endtask

    task automatic model_update();
        model_eval();
        if (rst) model_clear();
        else if (e_gd) begin
            t_live = 1; t_sent = 0; t_data = 1;
            t_addr = data_addr; t_wr = data_wr; t_size = data_size;
            t_wstrb = data_wr ? data_wstrb : 4'b0000; t_wdata = data_wdata;
            passed_over = inst_req ? ((passed_over < SM) ? passed_over + 1 : SM) : 0;
        end else if (e_gi) begin
            t_live = 1; t_sent = 0; t_data = 0;
            t_addr = inst_addr; t_wr = 0; t_size = 2'd2; t_wstrb = 4'b0000; t_wdata = '0;
            passed_over = 0;
        end else if (t_live && !t_sent) begin
            if (m_addr_ok) t_sent = 1;
        end else if (t_live && m_data_ok) t_live = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_addr = '0;
        data_req = 0; data_wr = 0; data_size = '0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        model_clear();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0) begin errors++; $display("FAIL reset_ok: got %b exp 0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}); end
            checks++; if ({m_req, busy} !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b exp 00", {m_req, busy}); end
            tick();
        end
        rst = 0;
        idle_inputs();
        @(negedge clk);
        checks++; if ({m_req, busy, m_wstrb} !== 6'b0) begin errors++; $display("FAIL reset_after: got %b exp 0", {m_req, busy, m_wstrb}); end
        tick();
    endtask

    task automatic test_single_fetch();
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00000;
        @(negedge clk);
        checks++; if ({inst_addr_ok, data_addr_ok, m_req} !== 3'b100) begin errors++; $display("FAIL fetch_t0: got %b exp 100", {inst_addr_ok, data_addr_ok, m_req}); end
        tick();
        inst_req = 0; m_addr_ok = 1;
        @(negedge clk);
        checks++; if ({m_req, busy} !== 2'b11) begin errors++; $display("FAIL fetch_t1_req: got %b exp 11", {m_req, busy}); end
        checks++; if (m_addr !== 32'hBFC00000) begin errors++; $display("FAIL fetch_t1_addr: got %h exp bfc00000", m_addr); end
        checks++; if ({m_wr, m_size, m_wstrb} !== 7'b0_10_0000) begin errors++; $display("FAIL fetch_t1_fields: got %b exp 0100000", {m_wr, m_size, m_wstrb}); end
        tick();
        m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h3C08BFC0;
        @(negedge clk);
        checks++; if ({m_req, inst_data_ok, data_data_ok} !== 3'b010) begin errors++; $display("FAIL fetch_t2_ok: got %b exp 010", {m_req, inst_data_ok, data_data_ok}); end
        checks++; if (rdata !== 32'h3C08BFC0) begin errors++; $display("FAIL fetch_t2_rdata: got %h exp 3c08bfc0", rdata); end
        tick();
        m_data_ok = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_t3_busy: got %b exp 0", busy); end
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00010;
        data_req = 1; data_wr = 1; data_size = 2'd1; data_addr = 32'h80000004;
        data_wstrb = 4'b1100; data_wdata = 32'hABCD0000;
        @(negedge clk);
        checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin errors++; $display("FAIL simul_grant: got %b exp 10", {data_addr_ok, inst_addr_ok}); end
        tick();
        data_req = 0; m_addr_ok = 1;
        @(negedge clk);
        checks++; if ({m_req, m_wr, m_size, m_wstrb} !== 8'b1_1_01_1100) begin errors++; $display("FAIL simul_fields: got %b exp 11011100", {m_req, m_wr, m_size, m_wstrb}); end
        checks++; if ({m_addr, m_wdata} !== {32'h80000004, 32'hABCD0000}) begin errors++; $display("FAIL simul_addr: got %h exp 80000004abcd0000", {m_addr, m_wdata}); end
        tick();
        m_addr_ok = 0; m_data_ok = 1;
        @(negedge clk);
        checks++; if ({data_data_ok, inst_data_ok, inst_addr_ok} !== 3'b100) begin errors++; $display("FAIL simul_resp: got %b exp 100", {data_data_ok, inst_data_ok, inst_addr_ok}); end
        tick();
        m_data_ok = 0;
        @(negedge clk);
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL simul_inst_next: got %b exp 10", {inst_addr_ok, data_addr_ok}); end
        tick();
    endtask

    task automatic test_starvation();
        bit exp_g[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int n = 0;
        do_reset();
        inst_req = 1; inst_addr = 32'h00001000;
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h00002000;
        m_addr_ok = 1; m_data_ok = 1;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (inst_addr_ok && data_addr_ok) begin checks++; errors++; $display("FAIL starve_double: both addr_ok at cycle %0d", c); end
            if (inst_addr_ok || data_addr_ok) begin
                checks++; if (data_addr_ok !== exp_g[n]) begin errors++; $display("FAIL starve_order: grant %0d got data=%b exp data=%b", n, data_addr_ok, exp_g[n]); end
                n++;
            end
            tick();
        end
        checks++; if (n !== 10) begin errors++; $display("FAIL starve_timeout: got %0d grants exp 10", n); end
        idle_inputs();
    endtask

    task automatic test_slow_memory();
        do_reset();
        data_req = 1; data_wr = 1; data_size = 2'd0; data_wstrb = 4'b0010;
        data_addr = 32'h80001235; data_wdata = 32'h0000EE00;
        @(negedge clk);
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL slow_grant: got %b exp 1", data_addr_ok); end
        tick();
        data_req = 0; inst_req = 1; inst_addr = 32'h00400000;
        for (int i = 0; i < 6; i++) begin
            m_addr_ok = (i == 5); m_data_ok = i[0];
            @(negedge clk);
            checks++; if ({m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata} !== {1'b1, 1'b1, 2'd0, 4'b0010, 32'h80001235, 32'h0000EE00}) begin errors++; $display("FAIL slow_addr_hold: cycle %0d got %b %h %h", i, {m_req, m_wr, m_size, m_wstrb}, m_addr, m_wdata); end
            checks++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin errors++; $display("FAIL slow_addr_ok: cycle %0d got %b exp 0000", i, {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            m_data_ok = (i == 7); m_addr_ok = i[0]; m_rdata = 32'hDEAD0000 + i;
            @(negedge clk);
            checks++; if ({m_req, busy, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== {2'b01, 3'b000, i == 7}) begin errors++; $display("FAIL slow_data: cycle %0d got %b", i, {m_req, busy, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
            tick();
        end
        m_data_ok = 0; m_addr_ok = 0;
        @(negedge clk);
        checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL slow_inst_after: got %b exp 1", inst_addr_ok); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_data();
        do_reset();
        inst_req = 1; inst_addr = 32'h00000100;
        tick();
        inst_req = 0; m_addr_ok = 1;
        tick();
        m_addr_ok = 0; rst = 1; m_data_ok = 1; m_rdata = 32'h11111111;
        @(negedge clk);
        checks++; if ({inst_data_ok, data_data_ok, busy} !== 3'b000) begin errors++; $display("FAIL rstdata_during: got %b exp 000", {inst_data_ok, data_data_ok, busy}); end
        tick();
        rst = 0; inst_req = 1; inst_addr = 32'h00000200;
        @(negedge clk);
        checks++; if ({inst_addr_ok, inst_data_ok, busy} !== 3'b100) begin errors++; $display("FAIL rstdata_after: got %b exp 100", {inst_addr_ok, inst_data_ok, busy}); end
        tick();
        inst_req = 0; m_data_ok = 0;
        @(negedge clk);
        checks++; if ({m_req, m_addr} !== {1'b1, 32'h00000200}) begin errors++; $display("FAIL rstdata_fresh: got %b %h exp 1 00000200", m_req, m_addr); end
        tick();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs[3] = '{32'h80010000, 32'h80010044, 32'h8001FFFC};
        int k = 0, nd = 0, last = 0;
        do_reset();
        data_wr = 0; data_size = 2'd2;
        m_addr_ok = 1; m_data_ok = 1;
        for (int c = 0; c < 12; c++) begin
            data_req = (k < 3);
            data_addr = (k < 3) ? addrs[k] : '0;
            m_rdata = m_addr ^ 32'h5A5A5A5A;
            @(negedge clk);
            if (data_data_ok) begin
                checks++; if (nd < 3 && rdata !== (addrs[nd] ^ 32'h5A5A5A5A)) begin errors++; $display("FAIL b2b_rdata: load %0d got %h", nd, rdata); end
                if (nd > 0) begin checks++; if (c - last !== 3) begin errors++; $display("FAIL b2b_spacing: load %0d got %0d cycles exp 3", nd, c - last); end end
                last = c; nd++;
            end
            if (data_addr_ok) k++;
            tick();
        end
        checks++; if (nd !== 3) begin errors++; $display("FAIL b2b_count: got %0d exp 3", nd); end
        idle_inputs();
    endtask

    task automatic test_random();
        bit ip = 0, dp = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; inst_addr = $urandom; end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1; data_wr = $urandom_range(0, 1); data_size = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
            end
            inst_req = ip; data_req = dp;
            m_addr_ok = $urandom_range(0, 1); m_data_ok = $urandom_range(0, 1); m_rdata = $urandom;
            @(negedge clk);
            model_eval();
            checks++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, m_req, busy} !== e_ctrl) begin errors++; $display("FAIL rand_ctrl: cycle %0d got %b exp %b", c, {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, m_req, busy}, e_ctrl); end
            if (e_ctrl[1]) begin
                checks++; if ({m_addr, m_wr, m_size, m_wstrb, m_wdata} !== {t_addr, t_wr, t_size, t_wstrb, t_wdata}) begin errors++; $display("FAIL rand_fields: cycle %0d got %h %b %b %h exp %h %b %b %h", c, m_addr, {m_wr, m_size}, m_wstrb, m_wdata, t_addr, {t_wr, t_size}, t_wstrb, t_wdata); end
            end
            if (e_ctrl[4] || e_ctrl[2]) begin
                checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata: cycle %0d got %h exp %h", c, rdata, m_rdata); end
            end
            if (e_gi) ip = 0;
            if (e_gd) dp = 0;
            model_update();
            tick();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        model_clear();
        tick();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_slow_memory();
        test_reset_mid_data();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
